fetch_prefetch_queue: RTL and testbench
=======================================

# fetch_prefetch_queue

Instruction prefetch buffer sitting directly upstream of the fetch stage, between the instruction memory port and `Fetch_cycle`. It issues sequential word fetches to a pipelined, in-order instruction memory and buffers up to `DEPTH` returned instructions with their PCs. It presents them to fetch through a valid/stall handshake. A redirect from branch, jump or prediction logic flushes the buffer and drops in-flight responses.

## Interface
- `DEPTH`, 4: buffer entries; power of two, ≥2; caps entries plus outstanding requests.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `NOP`, 32'h0000_0013: value of `InstrF` when `ValidF`=0.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `Redirect`  in  1  flush and restart at `RedirectPC`.
- `RedirectPC`  in  32  new fetch address, word aligned.
- `StallF`  in  1  fetch stage not consuming this cycle.
- `InstrF`  out  32  head instruction.
- `PCF`  out  32  PC of head instruction.
- `ValidF`  out  1  head entry valid.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  request address.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid; responses arrive in request order, ≥1 cycle after grant.
- `imem_rdata`  in  32  response data.

## Operation
- State: `fetch_pc` (next request address), `resp_pc` (PC of the next accepted response), `count` (buffered entries, 0..DEPTH), `outst` (granted requests awaiting response, 0..DEPTH), `discard` (responses still to drop, 0..DEPTH), and circular storage with read/write pointers.
- Issue: `imem_req` = !`Redirect` && (`count` + `outst` + `discard` < `DEPTH`). `imem_addr` = `fetch_pc`. Both are combinational from registers and `Redirect` only.
- Grant (`imem_req` && `imem_gnt`): `outst` +1 and `fetch_pc` +4, wrapping mod 2^32.
- While `imem_req`=1 and `imem_gnt`=0, `imem_addr` stays stable. A redirect may withdraw the request.
- Response with `discard`>0: `discard` −1 and the data is dropped.
- Response with `discard`=0: `outst` −1. `{imem_rdata, resp_pc}` is pushed and `resp_pc` +4.
- Push never overflows, because the issue rule reserves a slot.
- Pop: when `ValidF` && !`StallF`, the head is removed.
- Push and pop in the same cycle are both legal. `count` is unchanged.
- Output: `ValidF` = (`count`≠0). When valid, `InstrF`/`PCF` show the head entry. Otherwise `InstrF`=`NOP` and `PCF`=`resp_pc`.
- Redirect (has priority over everything):
  - `count` ← 0, pointers ← 0.
  - `fetch_pc` ← `RedirectPC`, `resp_pc` ← `RedirectPC`.
  - `discard` ← `discard` + `outst` − (1 if a response arrives this cycle), and `outst` ← 0.
  - Any response arriving in the redirect cycle is dropped.
  - A pop in the same cycle is ignored.
  - `StallF` is irrelevant.
- `RedirectPC` bits [1:0] are ignored and treated as 0.

## Timing
- Reset (async assert, sync-released use on next edge):
  - `count`=`outst`=`discard`=0, `fetch_pc`=`resp_pc`=`RESET_PC`.
  - Outputs: `ValidF`=0, `InstrF`=`NOP`, `PCF`=`RESET_PC`, `imem_req`=1, `imem_addr`=`RESET_PC`.
- Response at edge N is visible on `InstrF` in cycle N+1. Latency from grant to `ValidF` is memory latency + 1.
- Throughput is 1 instruction/cycle when `imem_gnt`=1, memory latency ≤ `DEPTH`−1, and `StallF`=0.
- Redirect asserted in cycle R:
  - `ValidF`=0 in R+1.
  - `imem_req`=1 with `imem_addr`=`RedirectPC` in R+1.
  - The first new instruction appears no earlier than R+3.
- Reset mid-operation: all state clears immediately. Responses in flight after reset release are ignored, because `discard`=0 and `outst`=0 mean they are never expected. The memory must be reset together with this block.

## Test plan
- Reset, `imem_gnt`=1, 1-cycle latency, memory word = address:
  - `imem_addr` 0,4,8,… in cycles 0,1,2,…
  - `ValidF`=1 from cycle 2, with `PCF`/`InstrF`=0,4,8,… one per cycle.
- Backpressure with `DEPTH`=4: hold `StallF`=1 from reset.
  - `imem_req` drops after 4 grants.
  - `count`=4, head `PCF`=0.
  - Release `StallF`: 0,4,8,12,16 drain in order, with no gap after the first.
- Grant stall: `imem_gnt`=0 for 3 cycles with `imem_req`=1 at addr 8.
  - `imem_addr` stays 8 throughout.
  - The grant then yields `PCF`=8, and no address is skipped.
- Redirect with latency 3 and 2 requests outstanding: `Redirect`=1, `RedirectPC`=0x100.
  - Next cycle `ValidF`=0 and `imem_addr`=0x100.
  - The two old responses are dropped.
  - The first valid output is `PCF`=0x100.
- Redirect coinciding with a response and with `StallF`=1: the response is not delivered, and the output sequence resumes at `RedirectPC`.
- Reset asserted with `count`=3 and `outst`=1: `ValidF`=0 immediately (asynchronous). After release `imem_addr`=`RESET_PC`.

Source files
------------

// File: rtl/fetch_prefetch_queue_if.sv
// Instruction-memory request/response bus between the prefetch queue (master)
// and a pipelined, in-order instruction memory (slave).
interface fetch_prefetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch buffer in front of the fetch stage. Issues sequential
// word fetches, buffers up to DEPTH returned instructions with their PCs and
// presents the head to fetch. A redirect flushes the buffer and arranges for
// responses that are still in flight to be dropped.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Redirect,
  input  logic [31:0]                   RedirectPC,
  input  logic                          StallF,
  output logic [31:0]                   InstrF,
  output logic [31:0]                   PCF,
  output logic                          ValidF,
  fetch_prefetch_queue_if.master        imem
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  // Occupancy sum needs headroom above the individual counter width.
  localparam int unsigned SW = CW + 2;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  localparam cnt_t          CNT_ZERO = cnt_t'(1'b0);
  localparam cnt_t          CNT_ONE  = cnt_t'(1'b1);
  localparam ptr_t          PTR_ZERO = ptr_t'(1'b0);
  localparam ptr_t          PTR_ONE  = ptr_t'(1'b1);
  localparam logic [SW-1:0] DEPTH_S  = SW'(DEPTH);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q,  resp_pc_d;
  cnt_t        count_q,    count_d;
  cnt_t        outst_q,    outst_d;
  cnt_t        discard_q,  discard_d;
  ptr_t        rd_ptr_q,   rd_ptr_d;
  ptr_t        wr_ptr_q,   wr_ptr_d;
  logic [31:0] ent_instr_q [DEPTH];
  logic [31:0] ent_instr_d [DEPTH];
  logic [31:0] ent_pc_q    [DEPTH];
  logic [31:0] ent_pc_d    [DEPTH];

  logic [SW-1:0] occupancy;
  logic          head_valid;
  logic          grant;
  logic          resp_expected;
  logic          resp_drop;
  logic          resp_take;
  logic          pop;
  logic [31:0]   redirect_pc_aligned;

  // Request issue and handshake decode; a slot is reserved for every request
  // so a response can always be stored when it returns.
  always_comb begin
    occupancy           = SW'(count_q) + SW'(outst_q) + SW'(discard_q);
    imem.imem_req       = !Redirect && (occupancy < DEPTH_S);
    imem.imem_addr      = fetch_pc_q;
    grant               = imem.imem_req && imem.imem_gnt;
    head_valid          = (count_q != CNT_ZERO);
    resp_expected       = (discard_q != CNT_ZERO) || (outst_q != CNT_ZERO);
    resp_drop           = imem.imem_rvalid && (discard_q != CNT_ZERO);
    resp_take           = imem.imem_rvalid && !Redirect &&
                          (discard_q == CNT_ZERO) && (outst_q != CNT_ZERO);
    pop                 = head_valid && !StallF && !Redirect;
    redirect_pc_aligned = RedirectPC & 32'hFFFF_FFFC;
  end

  // Head-of-queue presentation; an empty queue shows a NOP at the PC expected next.
  always_comb begin
    ValidF = head_valid;
    if (head_valid) begin
      InstrF = ent_instr_q[rd_ptr_q];
      PCF    = ent_pc_q[rd_ptr_q];
    end else begin
      InstrF = NOP;
      PCF    = resp_pc_q;
    end
  end

  // Next-state for PCs, counters, pointers and storage; redirect overrides everything.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    count_d     = count_q;
    outst_d     = outst_q;
    discard_d   = discard_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    ent_instr_d = ent_instr_q;
    ent_pc_d    = ent_pc_q;
    if (Redirect) begin
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
      count_d    = CNT_ZERO;
      rd_ptr_d   = PTR_ZERO;
      wr_ptr_d   = PTR_ZERO;
      outst_d    = CNT_ZERO;
      // Everything still outstanding becomes discard; a response landing now
      // is dropped here and so is no longer owed.
      if (imem.imem_rvalid && resp_expected) begin
        discard_d = discard_q + outst_q - CNT_ONE;
      end else begin
        discard_d = discard_q + outst_q;
      end
    end else begin
      fetch_pc_d = grant ? (fetch_pc_q + 32'd4) : fetch_pc_q;
      discard_d  = resp_drop ? (discard_q - CNT_ONE) : discard_q;
      outst_d    = outst_q + (grant ? CNT_ONE : CNT_ZERO) - (resp_take ? CNT_ONE : CNT_ZERO);
      count_d    = count_q + (resp_take ? CNT_ONE : CNT_ZERO) - (pop ? CNT_ONE : CNT_ZERO);
      rd_ptr_d   = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      if (resp_take) begin
        ent_instr_d[wr_ptr_q] = imem.imem_rdata;
        ent_pc_d[wr_ptr_q]    = resp_pc_q;
        wr_ptr_d              = wr_ptr_q + PTR_ONE;
        resp_pc_d             = resp_pc_q + 32'd4;
      end else begin
        wr_ptr_d  = wr_ptr_q;
        resp_pc_d = resp_pc_q;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      count_q     <= CNT_ZERO;
      outst_q     <= CNT_ZERO;
      discard_q   <= CNT_ZERO;
      rd_ptr_q    <= PTR_ZERO;
      wr_ptr_q    <= PTR_ZERO;
      ent_instr_q <= '{default: 32'h0000_0000};
      ent_pc_q    <= '{default: 32'h0000_0000};
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      count_q     <= count_d;
      outst_q     <= outst_d;
      discard_q   <= discard_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      ent_instr_q <= ent_instr_d;
      ent_pc_q    <= ent_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed testbench for fetch_prefetch_queue: a pipelined memory model with
// programmable latency, a stimulus process that also checks cycle-exact
// behaviour, and a monitor that scores every instruction fetch consumes
// against a queue of expected PCs.
module tb_fetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        StallF;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic        ValidF;

  fetch_prefetch_queue_if bus();

  int checks   = 0;
  int fails    = 0;
  int consumed = 0;
  int mem_lat  = 1;
  int base     = 0;

  logic [31:0] exp_q  [$];
  logic [31:0] mq_dat [$];
  int          mq_cnt [$];

  fetch_prefetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000),
    .NOP      (32'h0000_0013)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .StallF     (StallF),
    .InstrF     (InstrF),
    .PCF        (PCF),
    .ValidF     (ValidF),
    .imem       (bus)
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the address so data differs from PC.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_exp(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // Assert reset (checking the asynchronous reset outputs), then release it
  // so the caller is positioned at the start of cycle 0.
  task automatic do_reset(input logic stall);
    Redirect    = 1'b0;
    RedirectPC  = 32'h0000_0000;
    StallF      = stall;
    bus.imem_gnt = 1'b1;
    rst         = 1'b0;
    load_exp(32'h0000_0000);
    #1;
    chk("rst_valid", 32'(ValidF), 32'd0);
    chk("rst_instr", InstrF, 32'h0000_0013);
    chk("rst_pc",    PCF, 32'h0000_0000);
    chk("rst_req",   32'(bus.imem_req), 32'd1);
    chk("rst_addr",  bus.imem_addr, 32'h0000_0000);
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Pipelined in-order memory: grant seen in cycle k returns in cycle k+mem_lat.
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0000_0000;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mq_dat.delete();
        mq_cnt.delete();
        bus.imem_rvalid = 1'b0;
      end else if (bus.imem_req && bus.imem_gnt) begin
        mq_dat.push_back(mem_data(bus.imem_addr));
        mq_cnt.push_back(mem_lat);
      end
      @(posedge clk);
      #1;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0000_0000;
      if (rst) begin
        foreach (mq_cnt[i]) mq_cnt[i] = mq_cnt[i] - 1;
        if (mq_cnt.size() > 0 && mq_cnt[0] <= 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mq_dat[0];
          void'(mq_dat.pop_front());
          void'(mq_cnt.pop_front());
        end
      end else begin
        mq_dat.delete();
        mq_cnt.delete();
      end
    end
  end

  // Monitor: every instruction consumed by fetch must be the next expected one.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst && ValidF && !StallF && !Redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL mon_unexpected: got pc %h with no expected entry", PCF);
        end else begin
          e = exp_q.pop_front();
          chk("mon_pc", PCF, e);
          chk("mon_instr", InstrF, mem_data(e));
        end
        consumed++;
      end
    end
  end

  // Stimulus and cycle-exact checks.
  initial begin
    rst          = 1'b0;
    Redirect     = 1'b0;
    RedirectPC   = 32'h0000_0000;
    StallF       = 1'b0;
    bus.imem_gnt = 1'b1;

    // A: streaming, latency 1, full grant.
    base = consumed; mem_lat = 1;
    do_reset(1'b0);
    for (int c = 0; c < 10; c++) begin
      #2;
      chk("A_addr",  bus.imem_addr, 32'(4 * c));
      chk("A_req",   32'(bus.imem_req), 32'd1);
      chk("A_valid", 32'(ValidF), (c >= 2) ? 32'd1 : 32'd0);
      if (c >= 2) chk("A_pc", PCF, 32'(4 * (c - 2)));
      tick();
    end
    chk("A_outputs", 32'(consumed - base), 32'd8);

    // B: backpressure from reset, then drain.
    base = consumed;
    do_reset(1'b1);
    for (int c = 0; c < 8; c++) begin
      #2;
      chk("B_req", 32'(bus.imem_req), (c < 4) ? 32'd1 : 32'd0);
      if (c >= 5) begin
        chk("B_valid", 32'(ValidF), 32'd1);
        chk("B_head",  PCF, 32'h0000_0000);
      end
      tick();
    end
    StallF = 1'b0;
    for (int c = 8; c < 17; c++) begin
      #2;
      chk("B_drain_valid", 32'(ValidF), 32'd1);
      chk("B_drain_pc",    PCF, 32'(4 * (c - 8)));
      tick();
    end
    chk("B_outputs", 32'(consumed - base), 32'd9);

    // C: grant withheld for three cycles at address 8.
    base = consumed;
    do_reset(1'b0);
    for (int c = 0; c < 12; c++) begin
      bus.imem_gnt = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
      #2;
      if (c >= 2 && c <= 5) begin
        chk("C_addr", bus.imem_addr, 32'h0000_0008);
        chk("C_req",  32'(bus.imem_req), 32'd1);
      end
      if (c >= 4 && c <= 6) chk("C_gap", 32'(ValidF), 32'd0);
      if (c == 7) begin
        chk("C_valid", 32'(ValidF), 32'd1);
        chk("C_pc",    PCF, 32'h0000_0008);
      end
      tick();
    end
    chk("C_outputs", 32'(consumed - base), 32'd7);

    // D: redirect with latency 3 and two requests outstanding.
    base = consumed; mem_lat = 3;
    do_reset(1'b0);
    for (int c = 0; c < 10; c++) begin
      Redirect   = (c == 2);
      RedirectPC = 32'h0000_0100;
      if (c == 2) load_exp(32'h0000_0100);
      #2;
      if (c == 2) chk("D_req_in_redirect", 32'(bus.imem_req), 32'd0);
      if (c == 3) begin
        chk("D_req",  32'(bus.imem_req), 32'd1);
        chk("D_addr", bus.imem_addr, 32'h0000_0100);
      end
      if (c <= 6) chk("D_invalid", 32'(ValidF), 32'd0);
      if (c == 7) begin
        chk("D_valid", 32'(ValidF), 32'd1);
        chk("D_pc",    PCF, 32'h0000_0100);
      end
      tick();
    end
    Redirect = 1'b0;
    chk("D_outputs", 32'(consumed - base), 32'd3);

    // E: redirect coinciding with a response while stalled; low PC bits ignored.
    base = consumed; mem_lat = 1;
    do_reset(1'b1);
    for (int c = 0; c < 8; c++) begin
      Redirect   = (c == 2);
      RedirectPC = 32'h0000_0203;
      StallF     = (c < 3);
      if (c == 2) load_exp(32'h0000_0200);
      #2;
      if (c == 3) begin
        chk("E_valid0", 32'(ValidF), 32'd0);
        chk("E_addr",   bus.imem_addr, 32'h0000_0200);
        chk("E_pc0",    PCF, 32'h0000_0200);
        chk("E_instr0", InstrF, 32'h0000_0013);
      end
      if (c == 4) chk("E_valid4", 32'(ValidF), 32'd0);
      if (c == 5) begin
        chk("E_valid", 32'(ValidF), 32'd1);
        chk("E_pc",    PCF, 32'h0000_0200);
      end
      tick();
    end
    Redirect = 1'b0;
    chk("E_outputs", 32'(consumed - base), 32'd3);

    // F: reset asserted mid-cycle with three entries buffered and one outstanding.
    base = consumed;
    do_reset(1'b1);
    for (int c = 0; c < 4; c++) tick();
    #2;
    chk("F_prefill_valid", 32'(ValidF), 32'd1);
    chk("F_prefill_req",   32'(bus.imem_req), 32'd0);
    do_reset(1'b0);
    for (int c = 0; c < 4; c++) begin
      #2;
      chk("F_addr", bus.imem_addr, 32'(4 * c));
      if (c == 2) begin
        chk("F_valid", 32'(ValidF), 32'd1);
        chk("F_pc",    PCF, 32'h0000_0000);
      end
      tick();
    end
    chk("F_outputs", 32'(consumed - base), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
